// File: rtl/sn_to_bin.sv
// Stochastic-to-binary decoder: counts ones in a unipolar bitstream over a 2^LOG_LEN
// window and presents the scaled count on a valid/ready output register.
module sn_to_bin #(
    parameter int BIN_LEN = 8,
    parameter int LOG_LEN = BIN_LEN
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic               sng_enable,
    output logic               busy,
    output logic [BIN_LEN-1:0] out_val,
    output logic               out_valid,
    input  logic               out_ready
);
    localparam int CW    = LOG_LEN + 1;
    localparam int SHIFT = BIN_LEN - LOG_LEN;
    localparam logic [CW-1:0] WINDOW = {1'b1, {LOG_LEN{1'b0}}};
    localparam logic [CW-1:0] LAST   = WINDOW - CW'(1);

    if (LOG_LEN < 1 || LOG_LEN > BIN_LEN) begin : g_bad_log_len
        $error("sn_to_bin: LOG_LEN must be in 1..BIN_LEN");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]      ones_cnt_reg, ones_cnt_next;
    logic [BIN_LEN-1:0] out_val_reg, out_val_next;
    logic               out_valid_reg, out_valid_next;

    logic [CW-1:0]      ones_final;
    logic [BIN_LEN-1:0] scaled;
    logic [BIN_LEN-1:0] result;

    // The final sample of the window is folded in on the same edge that loads the result.
    assign ones_final = ones_cnt_reg + CW'(in_bit);
    assign scaled     = BIN_LEN'(ones_final) << SHIFT;
    assign result     = (ones_final == WINDOW) ? {BIN_LEN{1'b1}} : scaled;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            ones_cnt_reg  <= '0;
            out_val_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            ones_cnt_reg  <= ones_cnt_next;
            out_val_reg   <= out_val_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        ones_cnt_next  = ones_cnt_reg;
        out_val_next   = out_val_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = ACCUM;
                    bit_cnt_next  = '0;
                    ones_cnt_next = '0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    bit_cnt_next  = bit_cnt_reg + CW'(1);
                    ones_cnt_next = ones_final;
                    if (bit_cnt_reg == LAST) begin
                        state_next     = DONE;
                        out_val_next   = result;
                        out_valid_next = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_valid_reg && out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        endcase
    end

    assign sng_enable = (state_reg == ACCUM);
    assign busy       = (state_reg == ACCUM) || (state_reg == DONE);
    assign out_val    = out_val_reg;
    assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_sn_to_bin.sv
// Directed bench for sn_to_bin: an 8/8 instance for full windows, stalls, backpressure
// and reset, plus an 8/4 instance for the scaled short-window results.
module tb_sn_to_bin;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, bit8, valid8, ready8;
    logic       sng8, busy8, ovalid8;
    logic [7:0] val8;
    logic       start4, bit4, valid4, ready4;
    logic       sng4, busy4, ovalid4;
    logic [7:0] val4;

    int checks   = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    sn_to_bin #(.BIN_LEN(8), .LOG_LEN(8)) u_dut8 (
        .clock(clk), .reset(rst_n), .start(start8), .in_bit(bit8), .in_valid(valid8),
        .sng_enable(sng8), .busy(busy8), .out_val(val8), .out_valid(ovalid8),
        .out_ready(ready8)
    );

    sn_to_bin #(.BIN_LEN(8), .LOG_LEN(4)) u_dut4 (
        .clock(clk), .reset(rst_n), .start(start4), .in_bit(bit4), .in_valid(valid4),
        .sng_enable(sng4), .busy(busy4), .out_val(val4), .out_valid(ovalid4),
        .out_ready(ready4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: all ones, 1: alternating 1,0, 2: all zeros; optional 10-cycle stall
    // before valid sample stall_at; optional stray start pulse at valid sample 50.
    task automatic conv8(input int mode, input int stall_at, input bit poke,
                         output int accum);
        int vi;
        int stall_left;
        accum      = 0;
        vi         = 0;
        stall_left = (stall_at >= 0) ? 10 : 0;
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        while (sng8 === 1'b1 && accum < 600) begin
            accum++;
            if (vi == stall_at && stall_left > 0) begin
                valid8 = 1'b0;
                stall_left--;
            end else begin
                valid8 = 1'b1;
                bit8   = (mode == 0) ? 1'b1 : (mode == 1) ? (vi % 2 == 0) : 1'b0;
                vi++;
            end
            start8 = poke && (vi == 50);
            tick;
        end
        valid8 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic finish8(input string tag, input int wait_cycles, input int exp,
                           input bit poke);
        chk({tag, "_valid"}, int'(ovalid8), 1);
        chk({tag, "_val"}, int'(val8), exp);
        for (int i = 0; i < wait_cycles; i++) begin
            start8 = poke;
            tick;
            chk({tag, "_hold_valid"}, int'(ovalid8), 1);
            chk({tag, "_hold_val"}, int'(val8), exp);
        end
        start8 = poke;
        ready8 = 1'b1;
        tick;
        start8 = 1'b0;
        ready8 = 1'b0;
        chk({tag, "_xfer_valid"}, int'(ovalid8), 0);
        chk({tag, "_xfer_busy"}, int'(busy8), 0);
        chk({tag, "_retained"}, int'(val8), exp);
        tick;
        chk({tag, "_no_queue"}, int'(busy8), 0);
    endtask

    task automatic conv4(input string tag, input logic [15:0] pat, input int exp);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            valid4 = 1'b1;
            bit4   = pat[i];
            tick;
        end
        valid4 = 1'b0;
        chk({tag, "_valid"}, int'(ovalid4), 1);
        chk({tag, "_val"}, int'(val4), exp);
        ready4 = 1'b1;
        tick;
        ready4 = 1'b0;
        chk({tag, "_xfer"}, int'(ovalid4), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0; bit8 = 1'b0; valid8 = 1'b0; ready8 = 1'b0;
        start4 = 1'b0; bit4 = 1'b0; valid4 = 1'b0; ready4 = 1'b0;
        tick;
        tick;
        chk("rst_val", int'(val8), 0);
        chk("rst_valid", int'(ovalid8), 0);
        chk("rst_busy", int'(busy8), 0);
        chk("rst_sng", int'(sng8), 0);
        chk("rst_valid4", int'(ovalid4), 0);
        rst_n = 1'b1;
        tick;

        conv8(0, -1, 1'b0, cyc);
        chk("ones_sng_cycles", cyc, 256);
        finish8("ones", 0, 255, 1'b0);

        conv8(1, -1, 1'b0, cyc);
        chk("alt_cycles", cyc, 256);
        finish8("alt", 0, 128, 1'b0);

        conv8(2, -1, 1'b0, cyc);
        finish8("zeros", 0, 0, 1'b0);

        conv8(1, 60, 1'b0, cyc);
        chk("stall_cycles", cyc, 266);
        finish8("stall", 5, 128, 1'b0);

        conv8(0, -1, 1'b1, cyc);
        chk("poke_cycles", cyc, 256);
        finish8("poke", 3, 255, 1'b1);

        // Abort a window after 100 ones, then check a fresh run is uncontaminated.
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        valid8 = 1'b1;
        bit8   = 1'b1;
        for (int i = 0; i < 100; i++) tick;
        rst_n = 1'b0;
        tick;
        valid8 = 1'b0;
        chk("midrst_val", int'(val8), 0);
        chk("midrst_valid", int'(ovalid8), 0);
        chk("midrst_busy", int'(busy8), 0);
        chk("midrst_sng", int'(sng8), 0);
        rst_n = 1'b1;
        tick;
        chk("midrst_idle", int'(busy8), 0);
        conv8(1, -1, 1'b0, cyc);
        chk("fresh_cycles", cyc, 256);
        finish8("fresh", 0, 128, 1'b0);

        conv4("l4_five", 16'h8423, 80);
        conv4("l4_all", 16'hFFFF, 255);
        conv4("l4_eight", 16'h00FF, 128);
        conv4("l4_zero", 16'h0000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
